// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and one-cycle registered reads
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_write,
  input  logic [3:0]  d_data_wstrb,
  input  logic        d_write_enable,
  output logic [31:0] d_data_read,
  output logic        d_data_valid,
  output logic        uart_tx,
  output logic        tx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr, w_level;
  logic          r_ovf, r_en;
  logic [15:0]   r_div, w_div_m1;
  state_t        r_state, w_state;
  logic [15:0]   r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          w_hit, w_wr, w_rd, w_full, w_empty, w_pop, w_push_req, w_push, w_ovf_clr;
  logic [1:0]    w_sel;
  logic [31:0]   w_rdata;
  assign w_hit      = d_address[31:4] == BASE_ADDR[31:4];
  assign w_sel      = d_address[3:2];
  assign w_wr       = w_hit && d_write_enable && (d_data_wstrb != 4'b0);
  assign w_rd       = w_hit && !d_write_enable;
  assign w_level    = r_wptr - r_rptr;
  assign w_full     = w_level == PW'(FIFO_DEPTH);
  assign w_empty    = w_level == '0;
  assign w_pop      = (r_state == S_IDLE) && r_en && !w_empty;
  assign w_push_req = w_wr && (w_sel == 2'd0) && d_data_wstrb[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_clr  = w_wr && (w_sel == 2'd1) && d_data_wstrb[0] && d_data_write[3];
  assign w_div_m1   = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign uart_tx    = (r_state == S_START) ? 1'b0 : (r_state == S_DATA) ? r_shift[0] : 1'b1;
  assign tx_irq     = w_empty && (r_state == S_IDLE);
  // register read mux; TXDATA and unmapped bits read as zero
  always_comb begin
    w_rdata = (w_sel == 2'd1) ? {16'b0, 8'(w_level), 4'b0, r_ovf, r_state != S_IDLE, w_empty, w_full} :
              (w_sel == 2'd2) ? {16'b0, r_div} :
              (w_sel == 2'd3) ? {31'b0, r_en} : 32'b0;
  end
  // configuration, overflow flag and FIFO pointers; a dropped push beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_en   <= 1'b1;
      r_div  <= DEFAULT_DIV;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push_req && !w_push) r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_wr && w_sel == 2'd2 && d_data_wstrb[0]) r_div[7:0] <= d_data_write[7:0];
      if (w_wr && w_sel == 2'd2 && d_data_wstrb[1]) r_div[15:8] <= d_data_write[15:8];
      if (w_wr && w_sel == 2'd3 && d_data_wstrb[0]) r_en <= d_data_write[0];
    end
  end
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= d_data_write[7:0];
  end
  // registered read response, matching the data RAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      d_data_valid <= 1'b0;
      d_data_read  <= 32'b0;
    end else begin
      d_data_valid <= w_rd;
      d_data_read  <= w_rd ? w_rdata : 32'b0;
    end
  end
  // serialiser state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
    end
  end
  // serialiser next state: each bit lasts until the reloaded counter reaches zero
  always_comb begin
    w_state = r_state;
    w_cnt   = (r_state != S_IDLE && r_cnt != 16'd0) ? r_cnt - 16'd1 : r_cnt;
    w_bit   = r_bit;
    w_shift = r_shift;
    case (r_state)
      S_IDLE: if (w_pop) begin
        w_state = S_START;
        w_cnt   = w_div_m1;
        w_shift = r_mem[r_rptr[AW-1:0]];
      end
      S_START: if (r_cnt == 16'd0) begin
        w_state = S_DATA;
        w_cnt   = w_div_m1;
        w_bit   = 3'd0;
      end
      S_DATA: if (r_cnt == 16'd0) begin
        w_cnt   = w_div_m1;
        w_shift = r_shift >> 1;
        w_bit   = r_bit + 3'd1;
        w_state = (r_bit == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (r_cnt == 16'd0) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed bench against a queue-and-timer model of the UART
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_address = 32'h0;
  logic [31:0] d_data_write = 32'h0;
  logic [3:0]  d_data_wstrb = 4'h0;
  logic        d_write_enable = 1'b0;
  logic [31:0] d_data_read;
  logic        d_data_valid, uart_tx, tx_irq;
  int n_cmp = 0;
  int n_err = 0;
  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
    .clk(clk), .reset(reset), .d_address(d_address), .d_data_write(d_data_write),
    .d_data_wstrb(d_data_wstrb), .d_write_enable(d_write_enable), .d_data_read(d_data_read),
    .d_data_valid(d_data_valid), .uart_tx(uart_tx), .tx_irq(tx_irq));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: byte queue plus a frame timer counting down the cycles left in the frame
  logic [7:0]  m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_en = 1'b1;
  logic [15:0] m_div = 16'd868;
  int          m_busy = 0;
  int          m_fd = 1;
  logic [7:0]  m_byte = 8'h0;
  logic        m_vld = 1'b0;
  logic [31:0] m_rd = 32'h0;
  always @(posedge clk) begin
    logic hit;
    logic [1:0] sel;
    logic [31:0] st;
    bit pop;
    hit = d_address[31:4] == BASE[31:4];
    sel = d_address[3:2];
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0; m_en = 1'b1; m_div = 16'd868; m_busy = 0; m_vld = 1'b0; m_rd = 32'h0;
    end else begin
      st = {16'b0, 8'(m_q.size()), 4'b0, m_ovf, m_busy != 0, m_q.size() == 0, m_q.size() == DEPTH};
      m_vld = hit && !d_write_enable;
      m_rd = !m_vld ? 32'h0 : sel == 2'd1 ? st : sel == 2'd2 ? {16'b0, m_div} : sel == 2'd3 ? {31'b0, m_en} : 32'h0;
      pop = m_busy == 0 && m_en && m_q.size() > 0;
      if (m_busy > 0) m_busy--;
      if (pop) begin
        m_byte = m_q.pop_front();
        m_fd = (m_div == 16'd0) ? 1 : int'(m_div);
        m_busy = 10 * m_fd;
      end
      if (hit && d_write_enable) begin
        if (sel == 2'd1 && d_data_wstrb[0] && d_data_write[3]) m_ovf = 1'b0;
        if (sel == 2'd0 && d_data_wstrb[0]) begin
          if (m_q.size() < DEPTH) m_q.push_back(d_data_write[7:0]);
          else m_ovf = 1'b1;
        end
        if (sel == 2'd2 && d_data_wstrb[0]) m_div[7:0] = d_data_write[7:0];
        if (sel == 2'd2 && d_data_wstrb[1]) m_div[15:8] = d_data_write[15:8];
        if (sel == 2'd3 && d_data_wstrb[0]) m_en = d_data_write[0];
      end
    end
  end
  // every cycle: line level from frame position, irq, and read response
  always @(negedge clk) begin
    int k;
    logic exp_tx;
    k = (10 * m_fd - m_busy) / m_fd;
    exp_tx = (m_busy == 0) ? 1'b1 : (k == 0) ? 1'b0 : (k <= 8) ? m_byte[k-1] : 1'b1;
    check("uart_tx", {31'b0, uart_tx}, {31'b0, exp_tx});
    check("tx_irq", {31'b0, tx_irq}, {31'b0, m_busy == 0 && m_q.size() == 0});
    check("rd_valid", {31'b0, d_data_valid}, {31'b0, m_vld});
    check("rd_data", d_data_read, m_rd);
  end
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
    @(negedge clk);
    d_address = a; d_data_write = d; d_data_wstrb = s; d_write_enable = we;
    @(posedge clk);
    #1;
    d_address = 32'h0; d_data_write = 32'h0; d_data_wstrb = 4'h0; d_write_enable = 1'b0;
  endtask
  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    bus(BASE + {28'h0, off}, d, s, 1'b1);
  endtask
  task automatic rd(input logic [3:0] off, output logic [31:0] v);
    bus(BASE + {28'h0, off}, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    v = d_data_read;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("tx_after_reset", {31'b0, uart_tx}, 32'h1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame_len(input string tag, input int exp);
    int n;
    @(negedge clk);
    check({tag, "_pre"}, {31'b0, uart_tx}, 32'h1);
    @(negedge clk);
    check({tag, "_start"}, {31'b0, uart_tx}, 32'h0);
    n = 0;
    while (!tx_irq && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_len"}, n, exp);
  endtask
  task automatic drain(input int bound);
    int n;
    n = 0;
    while (!tx_irq && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'b0, tx_irq}, 32'h1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    logic [15:0] divs[4] = '{16'd1, 16'd2, 16'd3, 16'd5};
    idle(3);
    reset = 1'b0;
    rd(4'h4, v);
    check("status_reset", v, 32'h0000_0002);
    check("irq_reset", {31'b0, tx_irq}, 32'h1);
    rd(4'h8, v);
    check("div_reset", v, 32'd868);
    rd(4'hC, v);
    check("ctrl_reset", v, 32'h1);
    wr(4'h8, 32'd4, 4'h3);
    wr(4'h0, 32'hA5, 4'h1);
    frame_len("a5", 40);
    wr(4'h8, 32'd0, 4'h3);
    wr(4'h0, 32'hFF, 4'h1);
    frame_len("ff", 10);
    wr(4'h8, 32'd1000, 4'hF);
    for (int i = 0; i < 9; i++) wr(4'h0, i, 4'h1);
    rd(4'h4, v);
    check("status_full", v, 32'h0000_0805);
    wr(4'h0, 32'h09, 4'h1);
    rd(4'h4, v);
    check("status_ovf", v, 32'h0000_080D);
    wr(4'h4, 32'h8, 4'h0);
    rd(4'h4, v);
    check("ovf_nostrb", v, 32'h0000_080D);
    wr(4'h4, 32'h8, 4'h1);
    rd(4'h4, v);
    check("ovf_clear", v, 32'h0000_0805);
    pulse_reset();
    wr(4'h8, 32'd4, 4'h3);
    wr(4'h0, 32'h3C, 4'h1);
    wr(4'h0, 32'h55, 4'h1);
    idle(10);
    wr(4'hC, 32'h0, 4'h1);
    idle(50);
    rd(4'h4, v);
    check("held_byte", v, 32'h0000_0100);
    wr(4'hC, 32'h1, 4'h1);
    frame_len("reenable", 40);
    wr(4'h0, 32'h11, 4'h1);
    wr(4'h0, 32'h22, 4'h1);
    wr(4'h0, 32'h33, 4'h1);
    wr(4'h0, 32'h44, 4'h1);
    idle(15);
    pulse_reset();
    rd(4'h4, v);
    check("status_post_reset", v, 32'h0000_0002);
    rd(4'h8, v);
    check("div_post_reset", v, 32'd868);
    foreach (divs[p]) begin
      wr(4'h8, {16'h0, divs[p]}, 4'h3);
      for (int i = 0; i < 150; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) wr(4'h0, $urandom, 4'($urandom_range(0, 15)));
        else if (r < 65) rd(4'($urandom_range(0, 3) * 4), v);
        else if (r < 75) wr(4'hC, {31'b0, $urandom_range(0, 3) != 0}, 4'($urandom_range(0, 15)));
        else if (r < 85) wr(4'h4, $urandom, 4'($urandom_range(0, 15)));
        else if (r < 95) idle($urandom_range(0, 15));
        else bus((r[0] ? 32'h0000_1010 : 32'h0000_0FFC), $urandom, 4'hF, r[1]);
      end
      wr(4'hC, 32'h1, 4'h1);
      drain(2000);
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
